// File: rtl/nes_poll_controller.sv
// NES joypad poll sequencer: drives latch/clock, samples the serial line,
// and publishes the eight buttons as one atomic, active-high byte.
module nes_poll_controller #(
  parameter int HALF_BIT    = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       auto_en,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       changed,
  output logic       busy
);

  localparam int PH_W = $clog2(2 * HALF_BIT);
  localparam int TM_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

  localparam logic [PH_W-1:0] LATCH_LAST = PH_W'(2 * HALF_BIT - 1);
  localparam logic [PH_W-1:0] HALF_LAST  = PH_W'(HALF_BIT - 1);
  localparam logic [TM_W-1:0] TIMER_LAST = TM_W'(POLL_PERIOD - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LATCH    = 3'd1;
  localparam logic [2:0] ST_WAIT     = 3'd2;
  localparam logic [2:0] ST_PULSE_HI = 3'd3;
  localparam logic [2:0] ST_PULSE_LO = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      buttons_q;
  logic            latch_q, pulse_q, busy_q, valid_q, changed_q;
  logic [TM_W-1:0] timer_q, timer_d;
  logic            pending_q, pending_d;
  logic            sync1_q, sync2_q;
  logic            launch, sample_en, timer_wrap;

  // Two-flop synchronizer for the asynchronous, active-low joypad data line.
  // NOTE: no reset here on purpose; these flops only carry an external level
  // and are flushed within two cycles, so a reset term would add nothing.
  always_ff @(posedge clk) begin
    sync1_q <= nes_data;
    sync2_q <= sync1_q;
  end

  assign launch = (state_q == ST_IDLE) && (start || pending_q);

  // Poll sequencer next-state: phase counting, bit stepping and sampling.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d   = state_q;
    phase_d   = phase_q + 1'b1;
    bit_d     = bit_q;
    sample_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (launch) begin
          state_d = ST_LATCH;
          bit_d   = 3'd0;
        end
      end
      ST_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          state_d = ST_WAIT;
          phase_d = '0;
        end
      end
      ST_WAIT: begin
        if (phase_q == HALF_LAST) begin
          sample_en = 1'b1;
          bit_d     = 3'd1;
          state_d   = ST_PULSE_HI;
          phase_d   = '0;
        end
      end
      ST_PULSE_HI: begin
        if (phase_q == HALF_LAST) begin
          state_d = ST_PULSE_LO;
          phase_d = '0;
        end
      end
      ST_PULSE_LO: begin
        if (phase_q == HALF_LAST) begin
          sample_en = 1'b1;
          phase_d   = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_PULSE_HI;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
    shreg_d = sample_en ? {shreg_q[6:0], ~sync2_q} : shreg_q;
  end

  // Auto-poll timer and pending flag; an expiry during a poll is held until IDLE.
  always_comb begin
    timer_wrap = auto_en && (timer_q == TIMER_LAST);
    timer_d    = (!auto_en || timer_wrap) ? '0 : timer_q + 1'b1;
    pending_d  = pending_q;
    if (!auto_en) begin
      pending_d = 1'b0;
    end else if (timer_wrap) begin
      pending_d = 1'b1;
    end else if (launch) begin
      pending_d = 1'b0;
    end
  end

  // State, datapath and registered pin/strobe outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      bit_q     <= 3'd0;
      shreg_q   <= 8'h00;
      buttons_q <= 8'h00;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      timer_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      latch_q   <= (state_d == ST_LATCH);
      pulse_q   <= (state_d == ST_PULSE_HI);
      busy_q    <= state_d inside {ST_LATCH, ST_WAIT, ST_PULSE_HI, ST_PULSE_LO};
      valid_q   <= (state_d == ST_DONE);
      changed_q <= (state_d == ST_DONE) && (shreg_d != buttons_q);
      if (state_d == ST_DONE) begin
        buttons_q <= shreg_d;
      end
    end
  end

  assign nes_latch = latch_q;
  assign nes_pulse = pulse_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign changed   = changed_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nes_poll_controller.sv
// Self-checking bench for nes_poll_controller: joypad model, scoreboard of
// expected bytes, and a monitor that checks waveform timing of every poll.
module tb_nes_poll_controller;

  localparam int H        = 4;
  localparam int PERIOD   = 100;
  localparam int POLL_LEN = 17 * H + 2;
  localparam int VALID_AT = 17 * H + 1;

  logic       clk = 1'b0;
  logic       reset, start, auto_en;
  logic       nes_data;
  logic       nes_latch, nes_pulse, valid, changed, busy;
  logic [7:0] buttons;

  always #5 clk = ~clk;

  nes_poll_controller #(.HALF_BIT(H), .POLL_PERIOD(PERIOD)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .auto_en  (auto_en),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_pulse(nes_pulse),
    .buttons  (buttons),
    .valid    (valid),
    .changed  (changed),
    .busy     (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Joypad model: latch reloads, each pulse rising edge advances one button.
  logic [7:0] pad = 8'h00;
  int         idx = 0;
  logic       pad_pulse_prev = 1'b0;
  always @(posedge clk) begin
    pad_pulse_prev <= nes_pulse;
    if (nes_latch) idx <= 0;
    else if (nes_pulse && !pad_pulse_prev && idx < 8) idx <= idx + 1;
  end
  assign nes_data = (idx < 8) ? ~pad[3'(7 - idx)] : 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct packed {
    logic [7:0] btn;
    logic       chg;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int   launches[$];
  int   li = 0;
  int   cur_launch = 0;
  int   latch_first, latch_cnt, pulse_rises, pulse_run;
  bit   pulse_len_bad = 0, overlap = 0, glitch = 0, mon_en = 0;
  logic busy_prev = 1'b0, mon_pulse_prev = 1'b0, rst_edge = 1'b0;
  logic [7:0] btn_prev = 8'h00;

  always @(posedge clk) rst_edge <= reset;

  // Monitor: per-poll waveform bookkeeping and scoreboard comparison on valid.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !busy_prev) begin
        cur_launch = cyc - 1;
        launches.push_back(cur_launch);
        latch_first = -1; latch_cnt = 0; pulse_rises = 0; pulse_run = 0;
        pulse_len_bad = 0;
      end
      if (nes_latch) begin
        if (latch_first < 0) latch_first = cyc - cur_launch;
        latch_cnt++;
      end
      if (nes_pulse) begin
        if (!mon_pulse_prev) pulse_rises++;
        pulse_run++;
      end else if (mon_pulse_prev) begin
        if (pulse_run != H) pulse_len_bad = 1;
        pulse_run = 0;
      end
      if (nes_latch && nes_pulse) overlap = 1;
      if (buttons !== btn_prev && !valid && !rst_edge) glitch = 1;
      if (valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          check("buttons", buttons, mon_e.btn);
          check("changed", changed, mon_e.chg);
        end
        check("valid_latency", cyc - cur_launch, VALID_AT);
        check("latch_first", latch_first, 1);
        check("latch_len", latch_cnt, 2 * H);
        check("pulse_count", pulse_rises, 7);
        check("pulse_width_bad", pulse_len_bad, 0);
      end
      busy_prev      = busy;
      mon_pulse_prev = nes_pulse;
      btn_prev       = buttons;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valids(input string tag, input int n, input int budget);
    int seen = 0;
    int c = 0;
    while (seen < n && c < budget) begin
      @(negedge clk);
      c++;
      if (valid) seen++;
    end
    check({tag, "_valid_timeout"}, seen, n);
  endtask

  task automatic expect_launch(input string tag, input int exp_cyc);
    if (launches.size() > li) check(tag, launches[li], exp_cyc);
    else check({tag, "_missing"}, launches.size(), li + 1);
    li++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t1, a0;
    reset = 1'b1; start = 1'b0; auto_en = 1'b0;
    tick(3);
    check("rst_latch", nes_latch, 0);
    check("rst_pulse", nes_pulse, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_changed", changed, 0);
    check("rst_buttons", buttons, 8'h00);
    reset = 1'b0;
    mon_en = 1;
    tick(2);

    // Single start-launched poll, A + Start + Left pressed.
    pad = 8'h92;
    sb.push_back('{btn: 8'h92, chg: 1'b1});
    t0 = cyc;
    pulse_start();
    wait_valids("t1", 1, 200);
    expect_launch("t1_launch", t0);
    tick(5);

    // Same pad state again: no change reported.
    sb.push_back('{btn: 8'h92, chg: 1'b0});
    t0 = cyc;
    pulse_start();
    wait_valids("t2", 1, 200);
    expect_launch("t2_launch", t0);
    tick(5);

    // Start held high: back-to-back polls at the minimum spacing.
    pad = 8'h41;
    sb.push_back('{btn: 8'h41, chg: 1'b1});
    sb.push_back('{btn: 8'h41, chg: 1'b0});
    sb.push_back('{btn: 8'h41, chg: 1'b0});
    t0 = cyc;
    start = 1'b1;
    wait_valids("t3", 3, 400);
    start = 1'b0;
    expect_launch("t3_launch0", t0);
    expect_launch("t3_launch1", t0 + POLL_LEN);
    expect_launch("t3_launch2", t0 + 2 * POLL_LEN);
    tick(100);
    check("t3_no_extra", launches.size(), li);

    // Start pulses while busy (and in DONE) are neither honoured nor queued.
    pad = 8'h00;
    sb.push_back('{btn: 8'h00, chg: 1'b1});
    t0 = cyc;
    pulse_start();
    while (cyc < t0 + POLL_LEN) begin
      start = (cyc == t0 + 10) || (cyc == t0 + 30) || (cyc == t0 + 68) || (cyc == t0 + 69);
      @(negedge clk);
    end
    start = 1'b0;
    tick(100);
    expect_launch("t3b_launch", t0);
    check("t3b_no_extra", launches.size(), li);
    check("t3b_sb_drained", sb.size(), 0);

    // Auto polling every PERIOD cycles, then disabled mid-period.
    pad = 8'h18;
    sb.push_back('{btn: 8'h18, chg: 1'b1});
    sb.push_back('{btn: 8'h18, chg: 1'b0});
    sb.push_back('{btn: 8'h18, chg: 1'b0});
    a0 = cyc;
    auto_en = 1'b1;
    wait_valids("t4", 3, 500);
    expect_launch("t4_launch0", a0 + PERIOD);
    expect_launch("t4_launch1", a0 + 2 * PERIOD);
    expect_launch("t4_launch2", a0 + 3 * PERIOD);
    wait_until(a0 + 3 * PERIOD + 80);
    auto_en = 1'b0;
    tick(250);
    check("t4_no_extra", launches.size(), li);
    // Re-enable: a full period must elapse, so the timer was cleared.
    sb.push_back('{btn: 8'h18, chg: 1'b0});
    a0 = cyc;
    auto_en = 1'b1;
    wait_valids("t4b", 1, 300);
    auto_en = 1'b0;
    expect_launch("t4b_launch", a0 + PERIOD);
    tick(10);

    // Reset in the middle of a poll.
    t0 = cyc;
    pulse_start();
    wait_until(t0 + 30);
    check("t5_pulse_before_reset", nes_pulse, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_latch", nes_latch, 0);
    check("t5_pulse", nes_pulse, 0);
    check("t5_busy", busy, 0);
    check("t5_buttons", buttons, 8'h00);
    check("t5_valid", valid, 0);
    reset = 1'b0;
    tick(3);
    sb.push_back('{btn: 8'h18, chg: 1'b1});
    t1 = cyc;
    pulse_start();
    wait_valids("t5", 1, 200);
    expect_launch("t5_aborted_launch", t0);
    expect_launch("t5_launch", t1);
    tick(5);

    // Timer expiry during a start-launched poll launches right after it.
    pad = 8'hFF;
    sb.push_back('{btn: 8'hFF, chg: 1'b1});
    sb.push_back('{btn: 8'hFF, chg: 1'b0});
    a0 = cyc;
    auto_en = 1'b1;
    wait_until(a0 + 50);
    t1 = cyc;
    pulse_start();
    wait_valids("t6", 2, 300);
    auto_en = 1'b0;
    expect_launch("t6_launch0", t1);
    expect_launch("t6_launch1", t1 + POLL_LEN);
    tick(150);
    check("t6_no_extra", launches.size(), li);

    check("latch_pulse_overlap", overlap, 0);
    check("buttons_glitch", glitch, 0);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nes_poll_controller.md
# nes_poll_controller

Sequencer for a standard NES joypad. It generates the latch and clock (pulse) waveforms and samples the serial data line at defined points. It then presents the eight button states as an atomically updated, active-high byte with a one-cycle valid strobe. Polling is triggered by a `start` request or by an internal periodic timer. The block sits between the joypad pins and the game/decoder logic, replacing free-running shift capture with a deterministic per-frame poll.

## Interface
Parameters:
- `HALF_BIT`, default 300: clk cycles per half bit period (6 µs at 50 MHz); minimum 4.
- `POLL_PERIOD`, default 833333: clk cycles between automatic polls (60 Hz at 50 MHz); must exceed 17*HALF_BIT+2.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request one poll; honoured only in IDLE.
- `auto_en` in 1: enables periodic polling.
- `nes_data` in 1: joypad serial data, active-low, asynchronous.
- `nes_latch` out 1: joypad latch, registered.
- `nes_pulse` out 1: joypad clock, registered.
- `buttons` out 8: [7]=A [6]=B [5]=Select [4]=Start [3]=Up [2]=Down [1]=Left [0]=Right; 1 = pressed.
- `valid` out 1: one-cycle strobe when `buttons` updates.
- `changed` out 1: one-cycle strobe, coincident with `valid`, when the new byte differs from the previous one.
- `busy` out 1: a poll is in progress.

## Operation
- `nes_data` passes through a 2-flop synchronizer. The synchronizer is not reset. "Sampled value" means the inverted synchronizer output.
- FSM states: IDLE, LATCH, WAIT, PULSE_HI, PULSE_LO, DONE. A phase counter counts cycles within a state. A bit counter (0..7) tracks the current bit.
- IDLE → LATCH when `start` is high, or when the pending flag is set.
- LATCH lasts 2*HALF_BIT cycles with `nes_latch`=1.
- WAIT lasts HALF_BIT cycles with latch and pulse both 0. Bit 0 (A) is sampled on its last cycle.
- Bits 1..7 each take one PULSE_HI phase then one PULSE_LO phase:
  - PULSE_HI: HALF_BIT cycles with `nes_pulse`=1.
  - PULSE_LO: HALF_BIT cycles with `nes_pulse`=0; the bit is sampled on the last cycle.
  - After bit 7, go to DONE.
- Each sample shifts into an internal 8-bit register MSB-first: `shreg <= {shreg[6:0], sample}`. A lands in bit 7.
- DONE lasts 1 cycle and then returns to IDLE. In that cycle:
  - `buttons` <= `shreg`.
  - `valid`=1.
  - `changed` = (`shreg` != old `buttons`).
- `buttons` never shows a partial poll.
- Auto timer:
  - Counts 0..POLL_PERIOD-1 while `auto_en`=1; it is held at 0 when `auto_en`=0.
  - On reaching POLL_PERIOD-1 it wraps and sets the pending flag.
  - Pending is cleared when a poll launches, and when `auto_en` goes to 0.
- `start` while busy is ignored and not queued. A timer expiry while busy sets pending, and that poll launches on the first IDLE cycle.
- Reset (any state, including mid-poll): next cycle is IDLE, with all outputs 0, `buttons`=0, timer=0, pending=0, `shreg`=0.

## Timing
- Cycle 0 is the IDLE cycle in which the launch condition is true.
- `nes_latch`=1 during cycles 1..2H (H = HALF_BIT).
- Bit 0 is sampled at cycle 3H.
- For bit k = 1..7:
  - `nes_pulse`=1 during cycles 3H+(2k-2)H+1 .. 3H+(2k-1)H.
  - The sample is taken at cycle 3H+2kH.
- `busy`=1 during cycles 1..17H. `valid`/`changed` are asserted at cycle 17H+1 (DONE), and `buttons` changes that same cycle.
- The FSM is in IDLE at cycle 17H+2 and can launch a new poll then. The launch-to-launch minimum is 17H+2 cycles.
- Sampling latency: the sampled value reflects `nes_data` as it was 2 cycles before the sample cycle.
- `nes_latch` and `nes_pulse` are never high simultaneously.

## Test plan
- H=4, reset, pulse `start`, joypad model drives A,Start,Left pressed (active-low) → `nes_latch` high cycles 1-8, 7 pulses each 4 cycles high, `valid` at cycle 69, `buttons`=8'h92, `changed`=1.
- Repeat the same poll with the same joypad state → `valid`=1, `changed`=0, `buttons` stays 8'h92 with no intermediate values at any cycle.
- `start` held high continuously → launches at cycles 0, 70, 140; `start` pulses during `busy` cause no extra polls.
- H=4, POLL_PERIOD=100, `auto_en`=1, `start`=0 → launches every 100 cycles; `auto_en`=0 mid-period → no further launches, timer cleared.
- Assert `reset` for 1 cycle at cycle 30 of a poll → next cycle: latch=0, pulse=0, busy=0, buttons=8'h00, valid=0; a subsequent `start` completes normally.
- Timer expiry during a `start`-launched poll → second poll launches at exactly cycle 17H+2 after the first launch.
